// File: rtl/lsu_controller.sv
// Load/store sequencer: byte-addressed RV32I loads and stores
// mapped onto a word-addressed data memory with RMW for SB/SH.
module lsu_controller #(
    parameter int DEPTH = 256,
    parameter int IDX_W = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RMW_RD,
        WRITE,
        ERR,
        RESP
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    state_t state_q;
    state_t state_d;

    logic [2:0]       f3_q;
    logic [IDX_W+1:0] addr_q;
    logic [31:0]      wdata_q;
    logic [31:0]      merged_q;
    logic [31:0]      rdata_q;
    logic             err_q;

    logic [29:0] word_idx;
    logic        oor;
    logic        mis;
    logic        bad_f3;
    logic        req_err;

    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] lane_d;
    logic [31:0] merged_d;

    // Classify the incoming request: range, alignment, funct3 legality
    always_comb begin
        word_idx = req_addr_i[31:2];
        oor      = (word_idx >= 30'(DEPTH));
        mis      = 1'b0;
        bad_f3   = 1'b0;
        unique case (req_funct3_i)
            F3_B, F3_BU: mis = 1'b0;
            F3_H, F3_HU: mis = req_addr_i[0];
            F3_W:        mis = |req_addr_i[1:0];
            default:     bad_f3 = 1'b1;
        endcase
        if (req_we_i && req_funct3_i[2]) begin
            bad_f3 = 1'b1;
        end
        req_err = oor | mis | bad_f3;
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    if (req_err) begin
                        state_d = ERR;
                    end else if (!req_we_i) begin
                        state_d = LOAD;
                    end else if (req_funct3_i == F3_W) begin
                        state_d = WRITE;
                    end else begin
                        state_d = RMW_RD;
                    end
                end
            end
            LOAD:    state_d = RESP;
            RMW_RD:  state_d = WRITE;
            WRITE:   state_d = RESP;
            ERR:     state_d = RESP;
            RESP: begin
                if (resp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Lane extraction for loads and lane merge for sub-word stores
    always_comb begin
        lane_b = mem_rdata_i[{addr_q[1:0], 3'b000} +: 8];
        lane_h = mem_rdata_i[{addr_q[1], 4'b0000} +: 16];
        unique case (f3_q)
            F3_B:    lane_d = {{24{lane_b[7]}}, lane_b};
            F3_H:    lane_d = {{16{lane_h[15]}}, lane_h};
            F3_BU:   lane_d = {24'h0, lane_b};
            F3_HU:   lane_d = {16'h0, lane_h};
            default: lane_d = mem_rdata_i;
        endcase
        merged_d = mem_rdata_i;
        if (f3_q[0]) begin
            merged_d[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end else begin
            merged_d[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end
    end

    // Request latch, merged store word and response registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            f3_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            merged_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        f3_q    <= req_funct3_i;
                        addr_q  <= req_addr_i[IDX_W+1:0];
                        wdata_q <= req_wdata_i;
                    end
                end
                LOAD: begin
                    rdata_q <= lane_d;
                    err_q   <= 1'b0;
                end
                RMW_RD: merged_q <= merged_d;
                WRITE: begin
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                end
                ERR: begin
                    rdata_q <= '0;
                    err_q   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from state and the latched request
    always_comb begin
        req_ready_o  = (state_q == IDLE);
        resp_valid_o = (state_q == RESP);
        mem_we_o     = (state_q == WRITE);
        mem_addr_o   = {{(32-IDX_W){1'b0}}, addr_q[IDX_W+1:2]};
        mem_wdata_o  = (f3_q == F3_W) ? wdata_q : merged_q;
        resp_rdata_o = rdata_q;
        resp_err_o   = err_q;
    end

endmodule

// File: tb/tb_lsu_controller.sv
// Scoreboard bench for lsu_controller: directed cases plus
// randomized traffic checked against a byte-level memory model.
module tb_lsu_controller;

    localparam int DEPTH = 256;
    localparam int IDX_W = 8;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [2:0]  req_funct3_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        resp_valid_o;
    logic        resp_ready_i;
    logic [31:0] resp_rdata_o;
    logic        resp_err_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;

    always #5 clk_i = ~clk_i;

    lsu_controller #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_we_i     (req_we_i),
        .req_funct3_i (req_funct3_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready_i),
        .resp_rdata_o (resp_rdata_o),
        .resp_err_o   (resp_err_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rdata_i  (mem_rdata_i)
    );

    // Data memory: combinational read, synchronous write, bench pokes
    logic [31:0]      dmem [DEPTH];
    logic             poke_en;
    logic [IDX_W-1:0] poke_idx;
    logic [31:0]      poke_val;

    assign mem_rdata_i = dmem[mem_addr_o[IDX_W-1:0]];

    always @(posedge clk_i) begin
        if (mem_we_o) dmem[mem_addr_o[IDX_W-1:0]] <= mem_wdata_o;
        if (poke_en) dmem[poke_idx] <= poke_val;
    end

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Response-ready driver: random or forced level
    bit rr_rand;
    bit rr_force;
    always @(posedge clk_i) begin
        #2;
        resp_ready_i = rr_rand ? 1'($urandom_range(0, 1)) : rr_force;
    end

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          lat;
        int          acc;
    } rsp_t;

    typedef struct {
        logic [31:0] idx;
        logic [31:0] wd;
        int          lat;
        int          acc;
    } wr_t;

    rsp_t sbq[$];
    wr_t  wq[$];
    logic [31:0] ref_mem [DEPTH];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Reference model: byte-granular view of memory
    function automatic void model(
        input  logic        we,
        input  logic [2:0]  f3,
        input  logic [31:0] a,
        input  logic [31:0] wd,
        output logic [31:0] rd,
        output logic        err,
        output logic        wr,
        output int          idx,
        output logic [31:0] wv
    );
        int sz;
        bit sgn;
        bit legal;
        int off;
        longint unsigned word;
        longint unsigned val;
        longint unsigned msk;
        sz = 4; sgn = 0; legal = 1;
        case (f3)
            3'd0: begin sz = 1; sgn = 1; end
            3'd1: begin sz = 2; sgn = 1; end
            3'd2: sz = 4;
            3'd4: begin sz = 1; legal = !we; end
            3'd5: begin sz = 2; legal = !we; end
            default: legal = 0;
        endcase
        rd = 0; wr = 0; idx = 0; wv = 0;
        err = !legal || (a % sz != 0) || (a / 4 >= DEPTH);
        if (err) return;
        idx = int'(a / 4);
        off = int'(a % 4);
        word = longint'(ref_mem[idx]);
        if (!we) begin
            val = 0;
            for (int k = 0; k < sz; k++)
                val |= ((word >> (8 * (off + k))) & 64'hFF) << (8 * k);
            msk = (64'd1 << (8 * sz)) - 1;
            if (sgn && ((val >> (8 * sz - 1)) & 64'd1) == 64'd1)
                val = val | ~msk;
            rd = 32'(val);
        end else begin
            for (int k = 0; k < sz; k++) begin
                word = (word & ~(64'hFF << (8 * (off + k))))
                     | (((longint'(wd) >> (8 * k)) & 64'hFF)
                        << (8 * (off + k)));
            end
            wv = 32'(word);
            ref_mem[idx] = wv;
            wr = 1;
        end
    endfunction

    // Monitor: pops expectations as the DUT writes and responds
    bit   prev_v = 0;
    rsp_t mr;
    wr_t  mw;
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (mem_we_o) begin
                checks++;
                if (wq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: got addr %h data %h want none",
                             mem_addr_o, mem_wdata_o);
                end else begin
                    mw = wq.pop_front();
                    if (mem_addr_o !== mw.idx || mem_wdata_o !== mw.wd
                        || (cyc - mw.acc + 1) != mw.lat) begin
                        errors++;
                        $display("FAIL write: got addr %h data %h cyc %0d want addr %h data %h cyc %0d",
                                 mem_addr_o, mem_wdata_o, cyc - mw.acc + 1,
                                 mw.idx, mw.wd, mw.lat);
                    end
                end
            end
            if (resp_valid_o && !prev_v) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_resp: got rdata %h err %b want none",
                             resp_rdata_o, resp_err_o);
                end else if ((cyc - sbq[0].acc + 1) != sbq[0].lat) begin
                    errors++;
                    $display("FAIL resp_latency: got %0d want %0d",
                             cyc - sbq[0].acc + 1, sbq[0].lat);
                end
            end
            if (resp_valid_o && resp_ready_i && sbq.size() > 0) begin
                mr = sbq.pop_front();
                checks++;
                if (resp_rdata_o !== mr.rd || resp_err_o !== mr.err) begin
                    errors++;
                    $display("FAIL resp: got rdata %h err %b want rdata %h err %b",
                             resp_rdata_o, resp_err_o, mr.rd, mr.err);
                end
            end
        end
        prev_v = resp_valid_o;
    end

    task automatic poke(input int i, input logic [31:0] v);
        poke_idx = IDX_W'(i);
        poke_val = v;
        poke_en = 1'b1;
        ref_mem[i] = v;
        @(posedge clk_i); #1;
        poke_en = 1'b0;
    endtask

    // Present a request, wait for acceptance, push expectations
    task automatic issue(input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input bit has_exp, input logic [31:0] ev,
                         input logic ee, input bit track);
        logic [31:0] rd;
        logic [31:0] wv;
        logic        err;
        logic        wr;
        int          idx;
        int          n;
        rsp_t        r;
        wr_t         w;
        req_we_i = we;
        req_funct3_i = f3;
        req_addr_i = a;
        req_wdata_i = wd;
        req_valid_i = 1'b1;
        n = 0;
        while (!req_ready_o && n < 100) begin
            @(posedge clk_i); #1;
            n++;
        end
        if (!req_ready_o) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got ready 0 want 1");
            req_valid_i = 1'b0;
            return;
        end
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        if (!track) return;
        model(we, f3, a, wd, rd, err, wr, idx, wv);
        if (has_exp) begin
            err = ee;
            rd = we ? 32'h0 : ev;
            wv = ev;
        end
        r.rd = rd;
        r.err = err;
        r.lat = err ? 2 : ((we && f3 != 3'b010) ? 3 : 2);
        r.acc = cyc;
        sbq.push_back(r);
        if (wr && !err) begin
            w.idx = 32'(idx);
            w.wd = wv;
            w.lat = (f3 == 3'b010) ? 1 : 2;
            w.acc = cyc;
            wq.push_back(w);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sbq.size() != 0 || !req_ready_o) && n < 200) begin
            @(posedge clk_i); #1;
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got pending %0d want 0", sbq.size());
        end
    endtask

    logic [2:0] lf [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    initial begin
        logic        we;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] idx;
        logic [1:0]  off;
        int          n;

        rst_i = 1'b1;
        req_valid_i = 1'b0;
        req_we_i = 1'b0;
        req_funct3_i = 3'd0;
        req_addr_i = 32'h0;
        req_wdata_i = 32'h0;
        resp_ready_i = 1'b1;
        rr_rand = 0;
        rr_force = 1;
        poke_en = 1'b0;
        poke_idx = '0;
        poke_val = '0;
        @(posedge clk_i); #1;
        for (int i = 0; i < DEPTH; i++) poke(i, $urandom);
        poke(3, 32'h8899AABB);
        poke(5, 32'hAFAFAFAF);
        rst_i = 1'b0;

        chk("rst_req_ready", 32'(req_ready_o), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid_o), 32'd0);
        chk("rst_resp_rdata", resp_rdata_o, 32'd0);
        chk("rst_resp_err", 32'(resp_err_o), 32'd0);
        chk("rst_mem_we", 32'(mem_we_o), 32'd0);
        chk("rst_mem_wdata", mem_wdata_o, 32'd0);
        chk("rst_mem_addr", mem_addr_o, 32'd0);

        issue(0, 3'd0, 32'h0F, 0, 1, 32'hFFFFFF88, 0, 1);
        issue(0, 3'd4, 32'h0F, 0, 1, 32'h00000088, 0, 1);
        issue(0, 3'd1, 32'h0E, 0, 1, 32'hFFFF8899, 0, 1);
        issue(0, 3'd5, 32'h0C, 0, 1, 32'h0000AABB, 0, 1);
        issue(0, 3'd2, 32'h0C, 0, 1, 32'h8899AABB, 0, 1);
        issue(1, 3'd0, 32'h15, 32'h12345678, 1, 32'hAFAF78AF, 0, 1);
        issue(0, 3'd2, 32'h14, 0, 1, 32'hAFAF78AF, 0, 1);
        drain();
        poke(5, 32'h11223344);
        issue(1, 3'd1, 32'h16, 32'h0000CAFE, 1, 32'hCAFE3344, 0, 1);
        issue(1, 3'd2, 32'h18, 32'hDEADBEEF, 1, 32'hDEADBEEF, 0, 1);
        issue(0, 3'd2, 32'h02, 0, 1, 32'h0, 1, 1);
        issue(1, 3'd1, 32'h03, 32'h1234, 1, 32'h0, 1, 1);
        issue(0, 3'd0, 32'h400, 0, 1, 32'h0, 1, 1);
        issue(1, 3'd4, 32'h20, 32'h55, 1, 32'h0, 1, 1);
        drain();

        rr_force = 0;
        issue(0, 3'd2, 32'h0C, 0, 1, 32'h8899AABB, 0, 1);
        n = 0;
        while (!resp_valid_o && n < 20) begin
            @(posedge clk_i); #1;
            n++;
        end
        chk("bp_valid_seen", 32'(resp_valid_o), 32'd1);
        req_we_i = 1'b0;
        req_funct3_i = 3'd4;
        req_addr_i = 32'h0F;
        req_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(resp_valid_o), 32'd1);
            chk("bp_ready", 32'(req_ready_o), 32'd0);
            chk("bp_rdata", resp_rdata_o, 32'h8899AABB);
            @(posedge clk_i); #1;
        end
        rr_force = 1;
        issue(0, 3'd4, 32'h0F, 0, 1, 32'h00000088, 0, 1);
        drain();

        issue(1, 3'd0, 32'h15, 32'h000000EE, 0, 0, 0, 0);
        chk("rmw_no_we", 32'(mem_we_o), 32'd0);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        chk("mid_rst_ready", 32'(req_ready_o), 32'd1);
        chk("mid_rst_valid", 32'(resp_valid_o), 32'd0);
        @(posedge clk_i); #1;
        chk("mid_rst_mem", dmem[5], 32'hCAFE3344);
        issue(0, 3'd2, 32'h14, 0, 1, 32'hCAFE3344, 0, 1);
        drain();

        rr_rand = 1;
        for (int t = 0; t < 300; t++) begin
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) < 8)
                f3 = we ? lf[$urandom_range(0, 2)] : lf[$urandom_range(0, 4)];
            else
                f3 = 3'($urandom_range(0, 7));
            n = $urandom_range(0, 19);
            if (n == 0) idx = 32'($urandom_range(256, 1 << 29));
            else if (n == 1) idx = 32'($urandom_range(256, 259));
            else idx = 32'($urandom_range(0, 255));
            off = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) != 0) begin
                if (f3[1:0] == 2'd2) off = 2'd0;
                else if (f3[1:0] == 2'd1) off = off & 2'b10;
            end
            a = {idx[29:0], off};
            issue(we, f3, a, $urandom, 0, 0, 0, 1);
        end
        rr_rand = 0;
        rr_force = 1;
        drain();
        chk("resp_queue_empty", 32'(sbq.size()), 32'd0);
        chk("write_queue_empty", 32'(wq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
